// File: rtl/bcd_to_bin_serial.sv
// bcd_to_bin_serial: sequential packed-BCD to binary converter.
// Uses reverse double-dabble: each iteration shifts {bcd,bin} right by one,
// then subtracts 3 from every BCD digit that reads 8 or more.
// Optional feature macro: BCD2BIN_ERR_CHECK_EN (invalid-digit detection;
// a word with any digit > 9 skips conversion and reports err=1, bin_out=0).
module bcd_to_bin_serial #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int WORK_W = BCD_W + BIN_W;
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WORK_W-1:0]  work;       // {bcd part, bin part}
   logic [WORK_W-1:0]  work_step;
   logic [CNT_W-1:0]   cnt;
   logic               last_iter;
   logic               bad_digit;

   // One reverse double-dabble iteration: shift right, then correct each digit
   // based only on its own post-shift value (no borrow between digits).
   function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] v);
      logic [WORK_W-1:0] s;
      logic [3:0]        d;
      s = v >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         d = s[BIN_W + 4*i +: 4];
         if (d >= 4'd8) begin
            s[BIN_W + 4*i +: 4] = d - 4'd3;
         end else begin
            s[BIN_W + 4*i +: 4] = d;
         end
      end
      return s;
   endfunction

`ifdef BCD2BIN_ERR_CHECK_EN
   // True when any digit field holds a non-decimal code (A..F).
   function automatic logic has_bad_digit(input logic [BCD_W-1:0] b);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         r = r | (b[4*i +: 4] > 4'd9);
      end
      return r;
   endfunction

   assign bad_digit = has_bad_digit(in_bcd);
`else
   assign bad_digit = 1'b0;
`endif

   assign work_step = dabble_step(work);
   assign last_iter = (cnt == LAST_ITER);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept in IDLE, iterate BIN_W times, hold until taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (bad_digit) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = SHIFT;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (last_iter) begin
               state_nxt = DONE;
            end else begin
               state_nxt = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded directly from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         SHIFT:   in_ready  = 1'b0;
         DONE:    out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

`ifdef BCD2BIN_ERR_CHECK_EN
   logic err_flag;
   assign err = err_flag;
`else
   assign err = 1'b0;
`endif

   // Datapath: load on accept, iterate in SHIFT, capture result on the last
   // iteration. bin_out keeps its value after the output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         work    <= {WORK_W{1'b0}};
         cnt     <= {CNT_W{1'b0}};
         bin_out <= {BIN_W{1'b0}};
`ifdef BCD2BIN_ERR_CHECK_EN
         err_flag <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work <= {in_bcd, {BIN_W{1'b0}}};
                  cnt  <= {CNT_W{1'b0}};
`ifdef BCD2BIN_ERR_CHECK_EN
                  if (bad_digit) begin
                     bin_out  <= {BIN_W{1'b0}};
                     err_flag <= 1'b1;
                  end else begin
                     err_flag <= 1'b0;
                  end
`endif
               end
            end
            SHIFT: begin
               work <= work_step;
               cnt  <= cnt + CNT_W'(1);
               if (last_iter) begin
                  bin_out <= work_step[BIN_W-1:0];
               end
            end
            DONE: begin
               work <= work;
            end
            default: begin
               work <= work;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Self-checking bench for bcd_to_bin_serial: directed cases plus randomized
// decimal values whose expected binary result is the decimal number itself.
module tb_bcd_to_bin_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bcd;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] bin_out;
   logic        err;

   int checks   = 0;
   int failures = 0;

   bcd_to_bin_serial #(.DIGITS(4), .BIN_W(14)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pack a decimal number into four BCD digits.
   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] b;
      int          v;
      v = n;
      b = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         b[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return b;
   endfunction

   // Send one word, measure latency, check result, optionally backpressure,
   // then complete the output handshake. exp_val < 0 skips value checks.
   task automatic run_word(input logic [15:0] bcd, input int exp_val,
                           input int exp_lat, input int hold, input logic exp_err);
      int   cyc;
      logic busy_bad;
      @(negedge clk);
      check("idle_ready", in_ready, 1);
      in_bcd    = bcd;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_bcd   = 16'($urandom);
      cyc      = 0;
      busy_bad = 1'b0;
      while (!out_valid && cyc < 100) begin
         if (in_ready) busy_bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      check("busy_ready_low", busy_bad, 0);
      check("latency", cyc, exp_lat);
      check("err", err, exp_err);
      if (exp_val >= 0) check("bin", bin_out, exp_val);
      // Backpressure with a competing input word pending.
      in_valid = 1'b1;
      in_bcd   = 16'h0001;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_ready", in_ready, 0);
         check("hold_err", err, exp_err);
         if (exp_val >= 0) check("hold_bin", bin_out, exp_val);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_ready", in_ready, 1);
      if (exp_val >= 0) check("bin_retained", bin_out, exp_val);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_bcd    = 16'h0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_bin", bin_out, 0);
      check("rst_err", err, 0);

      run_word(16'h1234, 1234, 14, 0, 1'b0);
      run_word(16'h9999, 9999, 14, 0, 1'b0);
      run_word(16'h0000, 0, 14, 0, 1'b0);
      run_word(16'h0500, 500, 14, 5, 1'b0);

      // Reset on the 6th SHIFT cycle discards the conversion.
      @(negedge clk);
      in_bcd   = 16'h4321;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", in_ready, 1);
      check("midrst_valid", out_valid, 0);
      check("midrst_bin", bin_out, 0);
      check("midrst_err", err, 0);
      run_word(16'h0007, 7, 14, 0, 1'b0);

`ifdef BCD2BIN_ERR_CHECK_EN
      run_word(16'h12A4, 0, 0, 2, 1'b1);
`else
      run_word(16'h12A4, -1, 14, 0, 1'b0);
`endif

      run_word(to_bcd(9990), 9990, 14, 1, 1'b0);
      run_word(to_bcd(1), 1, 14, 0, 1'b0);
      run_word(to_bcd(8888), 8888, 14, 0, 1'b0);
      run_word(to_bcd(1000), 1000, 14, 0, 1'b0);

      for (int k = 0; k < 2500; k++) begin
         n = int'($urandom_range(0, 9999));
         run_word(to_bcd(n), n, 14, int'($urandom_range(0, 2)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
